// File: rtl/lsm_phase_sequencer.sv
// Phase sequencer for the LSM reservoir: steps TRAIN -> STDP -> READ for a set
// number of epochs and drives the reservoir control pins from registered state.
module lsm_phase_sequencer #(
  parameter int TRAIN_CYCLES = 950000,
  parameter int STDP_CYCLES  = 1000000,
  parameter int READ_CYCLES  = 4096,
  parameter int EPOCHS       = 1,
  parameter int CNT_W        = 24,
  parameter int EP_W         = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            pause,
  output logic            write,
  output logic            ST_and,
  output logic            CT_and,
  output logic            ST1,
  output logic            ST2,
  output logic            CT1,
  output logic            CT2,
  output logic            busy,
  output logic            done,
  output logic [2:0]      phase,
  output logic [EP_W-1:0] epoch
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRAIN = 3'd1,
    STDP  = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam longint MAX_CYC =
    (TRAIN_CYCLES > STDP_CYCLES)
      ? ((TRAIN_CYCLES > READ_CYCLES) ? longint'(TRAIN_CYCLES) : longint'(READ_CYCLES))
      : ((STDP_CYCLES  > READ_CYCLES) ? longint'(STDP_CYCLES)  : longint'(READ_CYCLES));

  if (TRAIN_CYCLES < 1 || STDP_CYCLES < 1 || READ_CYCLES < 1) begin : g_bad_cycles
    $error("lsm_phase_sequencer: every *_CYCLES parameter must be >= 1");
  end
  if (EPOCHS < 1) begin : g_bad_epochs
    $error("lsm_phase_sequencer: EPOCHS must be >= 1");
  end
  if (MAX_CYC - 1 >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("lsm_phase_sequencer: CNT_W too small for the longest phase");
  end
  if (longint'(EPOCHS) >= (longint'(1) << EP_W)) begin : g_bad_ep_w
    $error("lsm_phase_sequencer: EP_W too small to hold EPOCHS");
  end

  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STDP_LAST  = CNT_W'(STDP_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
  localparam logic [EP_W:0]    EPOCHS_W   = (EP_W+1)'(EPOCHS);

  // Control word order: {write, ST_and, CT_and, ST1, ST2, CT1, CT2}
  localparam logic [6:0] CTRL_TRAIN = 7'b1011011;
  localparam logic [6:0] CTRL_STDP  = 7'b1101110;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_last;
  logic [EP_W-1:0]   epoch_reg, epoch_next;
  logic [EP_W:0]     epoch_inc;
  logic [6:0]        ctrl_reg, ctrl_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  // State register: outputs are registered from the next-state decode so the
  // control word changes on the same edge as the phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      epoch_reg <= '0;
      ctrl_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      epoch_reg <= epoch_next;
      ctrl_reg  <= ctrl_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    cnt_last = '0;
    case (state_reg)
      TRAIN:   cnt_last = TRAIN_LAST;
      STDP:    cnt_last = STDP_LAST;
      READ:    cnt_last = READ_LAST;
      default: cnt_last = '0;
    endcase
  end

  assign epoch_inc = {1'b0, epoch_reg} + (EP_W+1)'(1);

  // Next-state decode: abort beats pause, pause beats counting.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    epoch_next = epoch_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = TRAIN;
          cnt_next   = '0;
          epoch_next = '0;
        end
      end
      TRAIN, STDP, READ: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!pause) begin
          if (cnt_reg == cnt_last) begin
            cnt_next = '0;
            case (state_reg)
              TRAIN:   state_next = STDP;
              STDP:    state_next = READ;
              default: begin
                epoch_next = epoch_inc[EP_W-1:0];
                state_next = (epoch_inc < EPOCHS_W) ? TRAIN : DONE;
              end
            endcase
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ctrl_next = '0;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      TRAIN: begin
        ctrl_next = CTRL_TRAIN;
        busy_next = 1'b1;
      end
      STDP: begin
        ctrl_next = CTRL_STDP;
        busy_next = 1'b1;
      end
      READ:    busy_next = 1'b1;
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  assign {write, ST_and, CT_and, ST1, ST2, CT1, CT2} = ctrl_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign phase = state_reg;
  assign epoch = epoch_reg;

endmodule

// File: tb/tb_lsm_phase_sequencer.sv
// Self-checking bench for lsm_phase_sequencer: a cycle reference model pushes
// expected output vectors to a scoreboard queue, popped after each clock edge.
module tb_lsm_phase_sequencer;

  localparam int TRAIN_C = 4;
  localparam int STDP_C  = 3;
  localparam int READ_C  = 2;
  localparam int EPOCHS  = 2;
  localparam int CNT_W   = 4;
  localparam int EP_W    = 8;

  logic            clock = 1'b0;
  logic            reset, start, abort, pause;
  logic            write, ST_and, CT_and, ST1, ST2, CT1, CT2, busy, done;
  logic [2:0]      phase;
  logic [EP_W-1:0] epoch;

  lsm_phase_sequencer #(
    .TRAIN_CYCLES(TRAIN_C), .STDP_CYCLES(STDP_C), .READ_CYCLES(READ_C),
    .EPOCHS(EPOCHS), .CNT_W(CNT_W), .EP_W(EP_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .write(write), .ST_and(ST_and), .CT_and(CT_and), .ST1(ST1), .ST2(ST2),
    .CT1(CT1), .CT2(CT2), .busy(busy), .done(done), .phase(phase), .epoch(epoch)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int stdp_seen = 0;
  logic [19:0] exp_q[$];

  int m_phase = 0;
  int m_cnt   = 0;
  int m_ep    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int phase_len(input int ph);
    case (ph)
      1:       return TRAIN_C;
      2:       return STDP_C;
      default: return READ_C;
    endcase
  endfunction

  task automatic model_step(input logic s, input logic a, input logic p, input logic r);
    if (r) begin
      m_phase = 0; m_cnt = 0; m_ep = 0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_cnt = 0; m_ep = 0; end
        4: m_phase = 0;
        default: begin
          if (a) begin
            m_phase = 0; m_cnt = 0;
          end else if (!p) begin
            if (m_cnt == phase_len(m_phase) - 1) begin
              m_cnt = 0;
              if (m_phase == 3) begin
                m_ep++;
                m_phase = (m_ep < EPOCHS) ? 1 : 4;
              end else begin
                m_phase++;
              end
            end else begin
              m_cnt++;
            end
          end
        end
      endcase
    end
  endtask

  // Expected {phase, epoch, busy, done, write, ST_and, CT_and, ST1, ST2, CT1, CT2}
  function automatic logic [19:0] model_vec();
    logic [6:0] c;
    logic       b, d;
    c = 7'b0000000;
    if (m_phase == 1) c = 7'b1011011;
    if (m_phase == 2) c = 7'b1101110;
    b = (m_phase >= 1 && m_phase <= 3);
    d = (m_phase == 4);
    return {3'(m_phase), 8'(m_ep), b, d, c};
  endfunction

  task automatic tick(input logic s, input logic a, input logic p, input logic r,
                      input bit glitch = 1'b0);
    logic [19:0] o, e;
    start = s; abort = a; pause = p; reset = r;
    model_step(s, a, p, r);
    exp_q.push_back(model_vec());
    if (glitch) begin
      #3 reset = 1'b1;
      #2 reset = 1'b0;
    end
    @(posedge clock);
    #1;
    o = {phase, epoch, busy, done, write, ST_and, CT_and, ST1, ST2, CT1, CT2};
    e = exp_q.pop_front();
    check_eq("cycle", 32'(o), 32'(e));
    if (done === 1'b1) done_seen++;
    if (phase === 3'd2) stdp_seen++;
    $display("t=%0t s=%0b a=%0b p=%0b r=%0b -> phase=%0d epoch=%0d busy=%0b done=%0b ctrl=%b",
             $time, s, a, p, r, phase, epoch, busy, done,
             {write, ST_and, CT_and, ST1, ST2, CT1, CT2});
  endtask

  initial begin
    // reset state
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);

    // single start pulse, full two-epoch run
    done_seen = 0;
    tick(1, 0, 0, 0);
    repeat (22) tick(0, 0, 0, 0);
    check_eq("run_done_pulses", 32'(done_seen), 32'd1);
    check_eq("run_final_epoch", 32'(epoch), 32'd2);

    // pause for 5 cycles at STDP count 1
    done_seen = 0; stdp_seen = 0;
    tick(1, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    repeat (5) tick(0, 0, 1, 0);
    repeat (30) tick(0, 0, 0, 0);
    check_eq("pause_stdp_cycles", 32'(stdp_seen), 32'd11);
    check_eq("pause_done_pulses", 32'(done_seen), 32'd1);

    // abort at TRAIN count 2, then a fresh full run
    done_seen = 0;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    check_eq("abort_no_done", 32'(done_seen), 32'd0);
    tick(1, 0, 0, 0);
    repeat (22) tick(0, 0, 0, 0);
    check_eq("abort_rerun_done", 32'(done_seen), 32'd1);

    // start held high: one run, then a restart from IDLE
    done_seen = 0;
    repeat (25) tick(1, 0, 0, 0);
    check_eq("held_start_done", 32'(done_seen), 32'd1);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);

    // glitch on reset between edges, then sync reset in READ
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0, 1'b1);
    repeat (5) tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check_eq("in_read_before_reset", 32'(phase), 32'd3);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
